// File: rtl/cpu_pkg.sv
// Core-wide datapath constants shared by every CPU block.
package cpu_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

// File: rtl/rf_wb_arbiter_pkg.sv
// Types shared by the writeback arbiter, its result FIFO and its bus interface.
package rf_wb_arbiter_pkg;
    import cpu_pkg::*;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
        logic                  kill;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_HEAD = 2'd2
    } grant_e;

    // Register x0 is hardwired to zero, so writes to it are never issued.
    function automatic logic writable(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Pipeline, multicycle-unit and register-file write signals of the writeback arbiter.
interface rf_wb_arbiter_if;
    import cpu_pkg::*;

    logic                  p_wr;
    logic [REG_ADDR_W-1:0] p_rd;
    logic [XLEN-1:0]       p_wd;
    logic                  p_stall;
    logic                  m_valid;
    logic                  m_ready;
    logic [REG_ADDR_W-1:0] m_rd;
    logic [XLEN-1:0]       m_wd;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wd;

    modport master (
        output p_wr, p_rd, p_wd, m_valid, m_rd, m_wd,
        input  p_stall, m_ready, rf_we, rf_rd, rf_wd
    );

    modport slave (
        input  p_wr, p_rd, p_wd, m_valid, m_rd, m_wd,
        output p_stall, m_ready, rf_we, rf_rd, rf_wd
    );
endinterface

// File: rtl/wb_fifo.sv
// Buffer of multicycle results awaiting the register-file write port; entries can be
// marked dead when the pipeline overwrites the same destination register first.
module wb_fifo
    import cpu_pkg::*;
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [REG_ADDR_W-1:0]   push_rd,
    input  logic [XLEN-1:0]         push_wd,
    input  logic                    pop,
    input  logic                    kill_en,
    input  logic [REG_ADDR_W-1:0]   kill_rd,
    output wb_entry_t               head,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [DEPTH-1:0] live;

    assign head = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = {1'b0, AW'(i) - rd_ptr} < count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && live[i] && mem[i].rd == kill_rd) begin
                    mem[i].kill <= 1'b1;
                end
            end
            if (push) begin
                mem[wr_ptr] <= '{rd: push_rd, wd: push_wd, kill: kill_en && (push_rd == kill_rd)};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between the pipeline and a buffered
// multicycle unit, forcing a pipeline stall when a buffered result waits too long.
module rf_wb_arbiter
    import cpu_pkg::*;
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int NW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [NW-1:0] FULL_CNT   = NW'(DEPTH);

    wb_entry_t             head;
    logic [NW-1:0]         count;
    logic [CW-1:0]         starve_cnt;
    grant_e                grant;
    logic                  empty;
    logic                  starve;
    logic                  p_req;
    logic                  push;
    logic                  pop;
    logic                  kill_en;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_rd_q;
    logic [XLEN-1:0]       rf_wd_q;

    assign bus.m_ready = count < FULL_CNT;
    assign bus.p_stall = starve && p_req;
    assign bus.rf_we   = rf_we_q;
    assign bus.rf_rd   = rf_rd_q;
    assign bus.rf_wd   = rf_wd_q;

    // A starving head beats the pipeline; otherwise the pipeline wins over the buffer.
    always_comb begin
        empty   = count == '0;
        starve  = (starve_cnt == STARVE_LIM) && !empty;
        p_req   = bus.p_wr && writable(bus.p_rd);
        push    = bus.m_valid && bus.m_ready && writable(bus.m_rd);
        grant   = GRANT_NONE;
        if (starve) begin
            grant = GRANT_HEAD;
        end else if (p_req) begin
            grant = GRANT_PIPE;
        end else if (!empty) begin
            grant = GRANT_HEAD;
        end
        pop     = grant == GRANT_HEAD;
        kill_en = grant == GRANT_PIPE;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_rd (bus.m_rd),
        .push_wd (bus.m_wd),
        .pop     (pop),
        .kill_en (kill_en),
        .kill_rd (bus.p_rd),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (!empty && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // A killed head is consumed silently; address and data simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else if (grant == GRANT_PIPE) begin
            rf_we_q <= 1'b1;
            rf_rd_q <= bus.p_rd;
            rf_wd_q <= bus.p_wd;
        end else if (grant == GRANT_HEAD && !head.kill) begin
            rf_we_q <= 1'b1;
            rf_rd_q <= head.rd;
            rf_wd_q <= head.wd;
        end else begin
            rf_we_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_rf_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          kill;
    } mdl_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    mdl_entry_t  mq[$];
    int          m_starve = 0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] exp_wd = '0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic p_wr, input logic [4:0] p_rd, input logic [31:0] p_wd,
                                 input logic m_valid, input logic [4:0] m_rd, input logic [31:0] m_wd);
        bus.p_wr    = p_wr;
        bus.p_rd    = p_rd;
        bus.p_wd    = p_wd;
        bus.m_valid = m_valid;
        bus.m_rd    = m_rd;
        bus.m_wd    = m_wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reference model: who owns the write port this cycle, per the arbitration rules.
    task automatic modelStep();
        int         size0;
        bit         p_req;
        bit         starve;
        bit         push;
        bit         popped;
        mdl_entry_t ne;
        mdl_entry_t h;
        size0  = mq.size();
        p_req  = bus.p_wr && bus.p_rd != 5'd0;
        starve = (m_starve == STARVE_MAX) && size0 > 0;
        push   = bus.m_valid && size0 < DEPTH && bus.m_rd != 5'd0;
        popped = 1'b0;
        ne.rd  = bus.m_rd;
        ne.wd  = bus.m_wd;
        ne.kill = 1'b0;
        exp_we = 1'b0;
        if (starve || (!p_req && size0 > 0)) begin
            h = mq.pop_front();
            popped = 1'b1;
            if (!h.kill) begin
                exp_we = 1'b1;
                exp_rd = h.rd;
                exp_wd = h.wd;
            end
        end else if (p_req) begin
            exp_we = 1'b1;
            exp_rd = bus.p_rd;
            exp_wd = bus.p_wd;
            foreach (mq[i]) if (mq[i].rd == bus.p_rd) mq[i].kill = 1'b1;
            if (bus.m_rd == bus.p_rd) ne.kill = 1'b1;
        end
        if (popped) m_starve = 0;
        else if (size0 > 0 && m_starve < STARVE_MAX) m_starve++;
        if (push) mq.push_back(ne);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_starve = 0;
            exp_we = 1'b0;
            exp_rd = '0;
            exp_wd = '0;
        end else begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        checkOutput("rf_we", {31'd0, bus.rf_we}, {31'd0, exp_we});
        checkOutput("rf_rd", {27'd0, bus.rf_rd}, {27'd0, exp_rd});
        checkOutput("rf_wd", bus.rf_wd, exp_wd);
        checkOutput("m_ready", {31'd0, bus.m_ready}, {31'd0, mq.size() < DEPTH});
        checkOutput("p_stall", {31'd0, bus.p_stall},
                    {31'd0, (m_starve == STARVE_MAX) && mq.size() > 0 && bus.p_wr && bus.p_rd != 5'd0});
        checkOutput("count", 32'(dut.u_fifo.count), 32'(mq.size()));
    end

    initial begin
        bus.p_wr = 0; bus.p_rd = 0; bus.p_wd = 0;
        bus.m_valid = 0; bus.m_rd = 0; bus.m_wd = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("reset m_ready", 32'(bus.m_ready), 32'd1);
        checkOutput("reset p_stall", 32'(bus.p_stall), 32'd0);
        checkOutput("reset count", 32'(dut.u_fifo.count), 32'd0);
        rst = 1'b0;
        idle(1);

        // Plain pipeline write
        applyStimulus(1, 5'd5, 32'hA5, 0, 5'd0, 32'd0);
        checkOutput("pipe rf_we", 32'(bus.rf_we), 32'd1);
        checkOutput("pipe rf_rd", 32'(bus.rf_rd), 32'd5);
        checkOutput("pipe rf_wd", bus.rf_wd, 32'hA5);
        idle(1);

        // Buffered result drains through an idle cycle
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd7, 32'h11);
        checkOutput("mpush count", 32'(dut.u_fifo.count), 32'd1);
        idle(1);
        checkOutput("mdrain count", 32'(dut.u_fifo.count), 32'd0);
        checkOutput("mdrain rf_we", 32'(bus.rf_we), 32'd1);
        checkOutput("mdrain rf_rd", 32'(bus.rf_rd), 32'd7);
        checkOutput("mdrain rf_wd", bus.rf_wd, 32'h11);
        idle(1);

        // Starvation forces a stall while the pipeline writes every cycle
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd10, 32'h100);
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd11, 32'h101);
        checkOutput("full m_ready", 32'(bus.m_ready), 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
        checkOutput("starve p_stall", 32'(bus.p_stall), 32'd1);
        applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
        checkOutput("starve rf_rd", 32'(bus.rf_rd), 32'd10);
        checkOutput("starve rf_wd", bus.rf_wd, 32'h100);
        checkOutput("after stall p_stall", 32'(bus.p_stall), 32'd0);
        applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
        checkOutput("resume rf_rd", 32'(bus.rf_rd), 32'd3);
        checkOutput("resume rf_wd", bus.rf_wd, 32'h33);
        idle(4);

        // Pipeline overwrite kills a buffered result
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'hDEAD);
        applyStimulus(1, 5'd9, 32'h22, 0, 5'd0, 32'd0);
        checkOutput("kill rf_wd", bus.rf_wd, 32'h22);
        idle(1);
        checkOutput("killed pop rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("killed pop count", 32'(dut.u_fifo.count), 32'd0);

        // Same-cycle push and pipeline write to one register
        applyStimulus(1, 5'd12, 32'h44, 1, 5'd12, 32'h55);
        idle(1);
        checkOutput("same-cycle kill rf_we", 32'(bus.rf_we), 32'd0);

        // Register zero is ignored on both sides
        applyStimulus(1, 5'd0, 32'h77, 1, 5'd0, 32'h88);
        checkOutput("x0 rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("x0 count", 32'(dut.u_fifo.count), 32'd0);
        idle(1);

        // Full buffer with a starve pop and a held m_valid: wrap and no push while full
        for (int k = 0; k < 10; k++) applyStimulus(1, 5'd4, 32'h40 + 32'(k), 1, 5'(20 + k), 32'h200 + 32'(k));
        idle(6);

        // Reset in the middle of activity
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd13, 32'h130);
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd14, 32'h140);
        applyStimulus(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
        #1 rst = 1'b1;
        #1;
        checkOutput("midreset rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("midreset rf_rd", 32'(bus.rf_rd), 32'd0);
        checkOutput("midreset m_ready", 32'(bus.m_ready), 32'd1);
        checkOutput("midreset p_stall", 32'(bus.p_stall), 32'd0);
        checkOutput("midreset count", 32'(dut.u_fifo.count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        checkOutput("post reset rf_we", 32'(bus.rf_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
